// File: rtl/output_slice_scheduler.sv
// Merges NUM_SLICES per-slice output-buffer beat streams into one picture-order
// beat stream with frame/line markers, behind a single registered output stage.
module output_slice_scheduler #(
   parameter int unsigned MAX_SLICE_WIDTH  = 2560,
   parameter int unsigned NUM_SLICES       = 2,
   parameter int unsigned MAX_FRAME_HEIGHT = 4096
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                sof,
   input  logic [$clog2(MAX_SLICE_WIDTH)-1:0]  slice_width,
   input  logic [$clog2(MAX_FRAME_HEIGHT):0]   frame_height,
   input  logic [NUM_SLICES-1:0]               in_valid,
   input  logic [NUM_SLICES*168-1:0]           in_data_p,
   output logic [NUM_SLICES-1:0]               in_ready,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [167:0]                        out_data_p,
   output logic                                out_sof,
   output logic                                out_eof,
   output logic                                out_sol,
   output logic                                out_eol,
   output logic                                busy,
   output logic                                cfg_err
);

   localparam int unsigned BEAT_W = 168;
   localparam int unsigned SW_W   = $clog2(MAX_SLICE_WIDTH);
   localparam int unsigned BW     = SW_W - 2;
   localparam int unsigned FH_W   = $clog2(MAX_FRAME_HEIGHT) + 1;
   localparam int unsigned IW     = $clog2(NUM_SLICES);

   localparam logic [IW-1:0] LAST_SLICE = IW'(NUM_SLICES - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_XFER  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [BW-1:0]     b_reg;
   logic [FH_W-1:0]   fh_reg;
   logic [BW-1:0]     beat_cnt;
   logic [IW-1:0]     slice_idx;
   logic [FH_W-1:0]   line_cnt;

   logic              cfg_ok_c;
   logic              load_en_c;
   logic              xfer_window_c;
   logic              xfer_c;
   logic              sel_valid_c;
   logic [BEAT_W-1:0] sel_data_c;
   logic [BW-1:0]     b_last_c;
   logic [FH_W-1:0]   fh_last_c;
   logic              last_beat_c;
   logic              last_slice_c;
   logic              last_line_c;
   logic              frame_end_c;
   logic              sol_c;
   logic              eol_c;

   // A zero-beat slice, a non-multiple-of-4 width or an empty picture is rejected.
   assign cfg_ok_c = (slice_width[1:0] == 2'b00) &&
                     (slice_width[SW_W-1:2] != '0) &&
                     (frame_height != '0);

   assign load_en_c     = ~out_valid | out_ready;
   assign xfer_window_c = (state == ST_XFER) && load_en_c && !sof;
   assign xfer_c        = xfer_window_c && sel_valid_c;

   assign b_last_c     = b_reg - BW'(1);
   assign fh_last_c    = fh_reg - FH_W'(1);
   assign last_beat_c  = (beat_cnt == b_last_c);
   assign last_slice_c = (slice_idx == LAST_SLICE);
   assign last_line_c  = (line_cnt == fh_last_c);
   assign frame_end_c  = xfer_c && last_beat_c && last_slice_c && last_line_c;

   assign sol_c = (beat_cnt == '0) && (slice_idx == '0);
   assign eol_c = last_beat_c && last_slice_c;

   // Current-slice source select
   always_comb begin
      sel_valid_c = 1'b0;
      sel_data_c  = '0;
      for (int i = 0; i < NUM_SLICES; i++) begin
         if (slice_idx == IW'(i)) begin
            sel_valid_c = in_valid[i];
            sel_data_c  = in_data_p[i*BEAT_W +: BEAT_W];
         end
      end
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < NUM_SLICES; i++) begin
         in_ready[i] = xfer_window_c && (slice_idx == IW'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // sof from any state restarts (or rejects) the frame
   always_comb begin
      state_nxt = state;
      if (sof) begin
         state_nxt = cfg_ok_c ? ST_XFER : ST_IDLE;
      end else begin
         case (state)
            ST_XFER:  if (frame_end_c) state_nxt = ST_DRAIN;
            ST_DRAIN: if (out_valid && out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_reg     <= '0;
         fh_reg    <= '0;
         beat_cnt  <= '0;
         slice_idx <= '0;
         line_cnt  <= '0;
      end else if (sof) begin
         beat_cnt  <= '0;
         slice_idx <= '0;
         line_cnt  <= '0;
         if (cfg_ok_c) begin
            b_reg  <= slice_width[SW_W-1:2];
            fh_reg <= frame_height;
         end
      end else if (xfer_c) begin
         if (last_beat_c) begin
            beat_cnt <= '0;
            if (last_slice_c) begin
               slice_idx <= '0;
               line_cnt  <= line_cnt + FH_W'(1);
            end else begin
               slice_idx <= slice_idx + IW'(1);
            end
         end else begin
            beat_cnt <= beat_cnt + BW'(1);
         end
      end
   end

   // Output stage: holds while stalled, empties when nothing is transferred
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data_p <= '0;
         out_sof    <= 1'b0;
         out_eof    <= 1'b0;
         out_sol    <= 1'b0;
         out_eol    <= 1'b0;
      end else if (sof) begin
         out_valid <= 1'b0;
      end else if (load_en_c) begin
         out_valid <= xfer_c;
         if (xfer_c) begin
            out_data_p <= sel_data_c;
            out_sol    <= sol_c;
            out_eol    <= eol_c;
            out_sof    <= sol_c && (line_cnt == '0);
            out_eof    <= eol_c && last_line_c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy    <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         busy    <= (state_nxt != ST_IDLE);
         cfg_err <= sof && !cfg_ok_c;
      end
   end

endmodule

// File: tb/tb_output_slice_scheduler.sv
// Scoreboard bench for output_slice_scheduler: a picture-order model builds the
// expected beat stream per frame, a negedge monitor checks every accepted beat.
module tb_output_slice_scheduler;

   localparam int NS   = 2;
   localparam int SW_W = 12;
   localparam int FH_W = 13;

   typedef struct packed {
      logic [167:0] d;
      logic         sof;
      logic         eof;
      logic         sol;
      logic         eol;
   } beat_t;

   logic               clk;
   logic               rst_n;
   logic               sof;
   logic [SW_W-1:0]    slice_width;
   logic [FH_W-1:0]    frame_height;
   logic [NS-1:0]      in_valid;
   logic [NS*168-1:0]  in_data_p;
   logic [NS-1:0]      in_ready;
   logic               out_valid;
   logic               out_ready;
   logic [167:0]       out_data_p;
   logic               out_sof, out_eof, out_sol, out_eol;
   logic               busy;
   logic               cfg_err;

   output_slice_scheduler #(
      .MAX_SLICE_WIDTH  (2560),
      .NUM_SLICES       (NS),
      .MAX_FRAME_HEIGHT (4096)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sof          (sof),
      .slice_width  (slice_width),
      .frame_height (frame_height),
      .in_valid     (in_valid),
      .in_data_p    (in_data_p),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data_p   (out_data_p),
      .out_sof      (out_sof),
      .out_eof      (out_eof),
      .out_sol      (out_sol),
      .out_eol      (out_eol),
      .busy         (busy),
      .cfg_err      (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int           n_tests = 0;
   int           n_fail  = 0;
   beat_t        exp_q[$];
   logic [167:0] src[NS][$];
   int           beats_seen = 0;
   int           pv = 100;
   int           rmode = 0;
   int           hold1 = 0;
   bit           junk = 0;
   int           cur_b = 0;
   int           src0_start = 0;
   logic [NS-1:0] take;

   task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [167:0] rand168();
      logic [191:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[167:0];
   endfunction

   // Monitor: compare each accepted beat, and hold-stability across stalls
   beat_t stall_snap;
   bit    stall_arm = 0;
   always @(negedge clk) begin
      beat_t cur;
      beat_t e;
      cur = {out_data_p, out_sof, out_eof, out_sol, out_eol};
      if (!rst_n) begin
         stall_arm = 0;
      end else begin
         if (stall_arm) begin
            check("stall_hold", 192'({out_valid, cur}), 192'({1'b1, stall_snap}));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_beat got=%0h exp=none at %0t", cur, $time);
            end else begin
               e = exp_q.pop_front();
               check("beat", 192'(cur), 192'(e));
               beats_seen++;
            end
         end
         stall_arm  = out_valid && !out_ready && !sof;
         stall_snap = cur;
      end
   end

   task automatic drive_inputs();
      for (int s = 0; s < NS; s++) begin
         bit v;
         if (junk) begin
            v = 1'b1;
            in_data_p[s*168 +: 168] = rand168();
         end else begin
            v = (src[s].size() != 0) && (int'($urandom_range(99)) < pv);
            if (s == 1 && hold1 > 0) v = 1'b0;
            in_data_p[s*168 +: 168] = (src[s].size() != 0) ? src[s][0] : '0;
         end
         in_valid[s] = v;
      end
      if (hold1 > 0) hold1--;
      case (rmode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = (int'($urandom_range(99)) < 70);
      endcase
   endtask

   task automatic cycle();
      @(negedge clk);
      take = in_valid & in_ready;
      if (hold1 > 0 && cur_b > 0 && src[0].size() == src0_start - cur_b)
         check("in_ready0_wait", 192'(in_ready[0]), 192'(0));
      @(posedge clk);
      #1;
      for (int s = 0; s < NS; s++)
         if (take[s] && src[s].size() != 0) void'(src[s].pop_front());
      drive_inputs();
   endtask

   // Reference: each slice supplies fh*B beats; picture order is line-major, slice, beat
   task automatic gen_frame(input int sw, input int fh);
      int b;
      beat_t e;
      b = sw / 4;
      cur_b = b;
      for (int s = 0; s < NS; s++)
         for (int k = 0; k < fh * b; k++) src[s].push_back(rand168());
      src0_start = src[0].size();
      for (int ln = 0; ln < fh; ln++)
         for (int s = 0; s < NS; s++)
            for (int k = 0; k < b; k++) begin
               e.d   = src[s][ln*b + k];
               e.sol = (s == 0) && (k == 0);
               e.eol = (s == NS-1) && (k == b-1);
               e.sof = e.sol && (ln == 0);
               e.eof = e.eol && (ln == fh-1);
               exp_q.push_back(e);
            end
   endtask

   task automatic start_frame(input int sw, input int fh);
      bit ok;
      ok = (sw != 0) && (sw % 4 == 0) && (fh != 0);
      sof          = 1'b1;
      slice_width  = SW_W'(sw);
      frame_height = FH_W'(fh);
      in_valid     = '0;
      @(negedge clk);
      check("in_ready_on_sof", 192'(in_ready), 192'(0));
      @(posedge clk);
      #1;
      sof = 1'b0;
      exp_q.delete();
      for (int s = 0; s < NS; s++) src[s].delete();
      cur_b = 0;
      if (ok) gen_frame(sw, fh);
      beats_seen = 0;
      check("cfg_err_after_sof", 192'(cfg_err), 192'(!ok));
      check("busy_after_sof", 192'(busy), 192'(ok));
      check("out_valid_after_sof", 192'(out_valid), 192'(0));
      drive_inputs();
   endtask

   task automatic run_frame(input int max_cycles);
      int n;
      bit busy_ok;
      n = 0;
      busy_ok = 1'b1;
      while (exp_q.size() != 0 && n < max_cycles) begin
         if (!busy) busy_ok = 1'b0;
         cycle();
         n++;
      end
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL frame_timeout got=%0d_beats_left exp=0", exp_q.size());
         exp_q.delete();
      end else begin
         check("busy_during_frame", 192'(busy_ok), 192'(1));
         check("busy_after_last", 192'(busy), 192'(0));
      end
   endtask

   task automatic mid_reset();
      rst_n = 1'b0;
      #1;
      check("rst_out", 192'({out_valid, out_data_p, out_sof, out_eof, out_sol, out_eol}), 192'(0));
      check("rst_ctl", 192'({in_ready, busy, cfg_err}), 192'(0));
      exp_q.delete();
      for (int s = 0; s < NS; s++) src[s].delete();
      cur_b = 0;
      junk = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_inputs();
      repeat (20) cycle();
      check("post_rst_idle", 192'({out_valid, busy, in_ready}), 192'(0));
      junk = 1'b0;
      drive_inputs();
   endtask

   initial begin
      int n;
      rst_n = 1'b0; sof = 1'b0; slice_width = '0; frame_height = '0;
      in_valid = '0; in_data_p = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", 192'(out_valid), 192'(0));
      check("reset_data", 192'(out_data_p), 192'(0));
      check("reset_markers", 192'({out_sof, out_eof, out_sol, out_eol}), 192'(0));
      check("reset_in_ready", 192'(in_ready), 192'(0));
      check("reset_busy_err", 192'({busy, cfg_err}), 192'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full-rate frame, then the same frame under a 1,0 ready pattern
      pv = 100; rmode = 0;
      start_frame(16, 2); run_frame(200);
      rmode = 1;
      start_frame(16, 2); run_frame(400);

      // Slice 1 starved at its first line segment
      rmode = 0; pv = 100; hold1 = 13;
      start_frame(8, 2); run_frame(400);
      hold1 = 0;

      // Rejected configuration, then a valid 3-beat-per-slice frame
      start_frame(10, 2);
      junk = 1'b1; drive_inputs();
      repeat (5) cycle();
      check("rejected_idle", 192'({in_ready, busy, cfg_err, out_valid}), 192'(0));
      junk = 1'b0; drive_inputs();
      start_frame(12, 2); run_frame(400);

      // Restart after five beats of a frame
      start_frame(16, 2);
      n = 0;
      while (beats_seen < 5 && n < 200) begin cycle(); n++; end
      check("five_beats_seen", 192'(beats_seen >= 5), 192'(1));
      start_frame(16, 3); run_frame(600);

      // Reset mid-frame
      start_frame(16, 4);
      repeat (10) cycle();
      mid_reset();

      // Single-beat slices and randomized frames
      rmode = 2; pv = 70;
      start_frame(4, 3); run_frame(600);
      for (int it = 0; it < 12; it++) begin
         pv    = int'($urandom_range(40, 100));
         rmode = int'($urandom_range(0, 2));
         start_frame(4 * int'($urandom_range(1, 8)), int'($urandom_range(1, 4)));
         run_frame(3000);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/output_slice_scheduler.md
OUTPUT_SLICE_SCHEDULER -- requirements
Module: output_slice_scheduler

Interface
REQ-001 SHALL have parameter MAX_SLICE_WIDTH, default 2560, maximum slice width in pixels.
REQ-002 SHALL have parameter NUM_SLICES, default 2, number of horizontal slices per picture line (2..8).
REQ-003 SHALL have parameter MAX_FRAME_HEIGHT, default 4096, maximum picture height in lines.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port sof  input  1  start-of-frame pulse; latches configuration and arms the scheduler.
REQ-007 SHALL have port slice_width  input  $clog2(MAX_SLICE_WIDTH)  slice width in pixels, sampled on sof.
REQ-008 SHALL have port frame_height  input  $clog2(MAX_FRAME_HEIGHT)+1  picture height in lines, sampled on sof.
REQ-009 SHALL have port in_valid  input  NUM_SLICES  per-slice output-buffer beat valid.
REQ-010 SHALL have port in_data_p  input  NUM_SLICES*168  per-slice 4-pixel beat, slice i at bits [i*168+:168], packed {p3c2..p0c0} as produced by the slice output buffers.
REQ-011 SHALL have port in_ready  output  NUM_SLICES  per-slice beat accept.
REQ-012 SHALL have port out_valid  output  1  registered output beat valid.
REQ-013 SHALL have port out_ready  input  1  downstream accept.
REQ-014 SHALL have port out_data_p  output  168  4-pixel picture beat, same packing as in_data_p.
REQ-015 SHALL have ports out_sof, out_eof, out_sol, out_eol  output  1 each  frame/line markers qualified by out_valid.
REQ-016 SHALL have port busy  output  1  high from accepted sof until last frame beat is accepted downstream.
REQ-017 SHALL have port cfg_err  output  1  one-cycle pulse on a rejected sof.

Function
REQ-018 Beats per slice line SHALL be B = slice_width>>2; a picture line SHALL be slice 0 line, then slice 1, ... slice NUM_SLICES-1, each B beats in order.
REQ-019 On sof with slice_width==0, slice_width[1:0]!=0, or frame_height==0, SHALL pulse cfg_err next cycle, stay IDLE, ignore in_valid.
REQ-020 FSM states: IDLE, XFER, DRAIN. IDLE->XFER on valid sof; XFER->DRAIN when last beat of frame loads into output register; DRAIN->IDLE when that beat is accepted (out_valid & out_ready).
REQ-021 Counters: beat_cnt (0..B-1), slice_idx (0..NUM_SLICES-1), line_cnt (0..frame_height-1), all cleared on valid sof.
REQ-022 A transfer SHALL occur when state==XFER, in_valid[slice_idx]=1 and load_en=1, where load_en = ~out_valid | out_ready.
REQ-023 in_ready[i] SHALL equal (state==XFER) & (i==slice_idx) & load_en; all other bits 0; in_ready SHALL not depend on in_valid.
REQ-024 On transfer: beat_cnt increments; at B-1 it wraps to 0 and slice_idx increments; at slice NUM_SLICES-1 slice_idx wraps to 0 and line_cnt increments.
REQ-025 Latency SHALL be one cycle: transferred beat appears on out_data_p/out_valid the cycle after transfer.
REQ-026 out_sol=1 for beat_cnt==0 & slice_idx==0; out_eol=1 for beat_cnt==B-1 & slice_idx==NUM_SLICES-1; out_sof adds line_cnt==0 to out_sol; out_eof adds line_cnt==frame_height-1 to out_eol.
REQ-027 While out_valid & ~out_ready, out_data_p and all markers SHALL hold stable.
REQ-028 If load_en=1 and no transfer occurs, out_valid SHALL deassert next cycle.
REQ-029 sof while busy SHALL abort current frame: out_valid cleared next cycle, in-flight beat discarded, counters cleared, new configuration latched (or cfg_err/IDLE if invalid).
REQ-030 sof coinciding with a transfer SHALL take priority; the transfer is not performed (in_ready forced 0 in that cycle).
REQ-031 B=1 (slice_width=4) SHALL be supported; sol and eol then assert on same beat of the respective slices.

Reset
REQ-032 On rst_n=0: state IDLE, counters 0, out_valid=0, out_data_p=0, all markers 0, in_ready=0, busy=0, cfg_err=0.
REQ-033 Reset mid-frame SHALL discard all state; no beat SHALL emerge until a new valid sof.

Verification
REQ-034 slice_width=16, frame_height=2, NUM_SLICES=2, in_valid all 1, out_ready=1 -> 16 beats, out_sof on beat 0, out_sol on beats 0 and 8, out_eol on 7 and 15, out_eof on 15, slice order 0,0,0,0,1,1,1,1 per line.
REQ-035 Same config, out_ready toggled 1,0 every cycle -> identical beat sequence, data/markers stable during every stall, no beat lost or duplicated.
REQ-036 slice_width=8, slice 1 in_valid low for 10 cycles at line start of slice 1 -> in_ready[0]=0 throughout, scheduler waits, order preserved.
REQ-037 sof with slice_width=10 -> cfg_err pulse, busy=0, in_ready=0; subsequent sof with slice_width=12 -> normal 3 beats/slice.
REQ-038 sof asserted after 5 beats of a frame -> out_valid low next cycle, new frame starts with out_sof on its first beat, busy continuous.
REQ-039 rst_n low mid-frame for 1 cycle -> all outputs at reset values; no output until next sof.
